marker_lockstep_ctrl: RTL and testbench
=======================================

Name: marker_lockstep_ctrl

Overview:
- Lockstep controller for the DUT and variant SoC instances in differential taint simulation.
- Watches each side's ROB commit lanes for phase-marker instructions and stalls whichever core reaches a marker first until the peer commits the same marker. Both cores then enter each phase (INIT, TRAIN, BIM, VCTM, DELAY, TEXE, LEAK) aligned.
- Reports the current phase and marker count, and flags divergence, timeout and overrun errors for the event logger.

Parameters:
- NLANE, 2, commit lanes per side.
- TIMEOUT, 4096, max cycles one side may wait for its peer.
- CNT_W, 16, width of marker counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  lockstep enable; low forces IDLE and releases both stalls.
- dut_commit_valid  in  NLANE  per-lane commit valid, DUT.
- dut_commit_inst  in  32*NLANE  per-lane committed instruction, DUT; lane i is bits [32i+31:32i].
- vnt_commit_valid  in  NLANE  per-lane commit valid, variant.
- vnt_commit_inst  in  32*NLANE  per-lane committed instruction, variant.
- dut_stall  out  1  registered commit stall to DUT.
- vnt_stall  out  1  registered commit stall to variant.
- phase_id  out  3  last matched marker code >> 1.
- phase_active  out  1  high between a matched START and its END.
- marker_cnt  out  CNT_W  number of matched marker pairs; wraps.
- sync_pulse  out  1  one-cycle pulse on each matched pair.
- err  out  1  sticky error.
- err_code  out  2  0 none, 1 mismatch, 2 timeout, 3 overrun.

Behaviour:
- Marker decode:
  - A lane holds a marker when valid=1, inst[19:0]=20'h02013, inst[31:24]=0 and inst[23:20]<=4'hd.
  - code = inst[23:20]. Even code = START, odd code = END.
- Per side per cycle, the lowest-index marker lane is taken. A second marker on that side in the same cycle sets overrun.
- All outputs reset to 0. State resets to IDLE. The wait counter resets to 0.
- FSM states: IDLE, RUN, DUT_WAIT, VNT_WAIT, ERROR.
- IDLE:
  - Stalls are 0.
  - Goes to RUN on enable=1.
- RUN:
  - Both sides give a marker in the same cycle with equal codes: stay in RUN and apply a match.
  - Both sides give a marker in the same cycle with unequal codes: go to ERROR, mismatch.
  - Only the DUT gives a marker: latch its code, go to DUT_WAIT, dut_stall=1 from the next cycle.
  - Only the variant gives a marker: symmetric, going to VNT_WAIT with vnt_stall=1.
- DUT_WAIT (VNT_WAIT is symmetric):
  - Each cycle the wait counter increments.
  - Variant marker equal to the latched code: apply a match, go to RUN, dut_stall=0 next cycle, counter cleared.
  - Variant marker not equal to the latched code: ERROR, mismatch.
  - DUT commits any marker while waiting (one-cycle stall latency is not an excuse): ERROR, overrun.
  - Counter reaches TIMEOUT-1 with no peer marker: ERROR, timeout.
  - If timeout and a peer marker occur in the same cycle, the marker wins.
- Apply a match, effective next cycle:
  - sync_pulse=1 for one cycle.
  - marker_cnt increments, wrapping from all-ones to 0.
  - phase_id = code>>1.
  - phase_active = ~code[0].
- ERROR:
  - Both stalls are 0 so simulation can finish.
  - err=1 and err_code latch the first cause. Later errors do not overwrite it.
  - ERROR is exited only by reset.
- If enable falls in any state other than ERROR: next state IDLE, stalls 0, wait counter 0. phase_id, phase_active and marker_cnt are held.
- Error priority within one cycle: overrun > mismatch > timeout.
- Asynchronous reset asserted mid-wait drops the stall immediately, in the same time step, and clears all state.

Test Plan:
- Reset low, then high with enable=1 and no commits -> RUN; all outputs 0.
- DUT lane0 commits 32'h00802013 at cycle 10, variant lane1 commits 32'h00802013 at cycle 15 -> dut_stall=1 during cycles 11..15, 0 at 16; sync_pulse at 16; phase_id=4, phase_active=1, marker_cnt=1.
- Both sides commit 32'h00902013 in the same cycle -> no stall; sync_pulse next cycle; phase_active=0; marker_cnt increments.
- DUT commits 32'h00402013, variant then commits 32'h00602013 -> err=1, err_code=1, both stalls 0.
- TIMEOUT=8; variant commits a marker and the DUT never does -> vnt_stall high for 8 cycles, then err_code=2 and vnt_stall=0.
- DUT commits two markers in lanes 0 and 1 in one cycle -> err_code=3. Separately, with CNT_W=2, after 4 matches -> marker_cnt wraps to 0.

Source files
------------

// File: rtl/marker_lockstep_ctrl.sv
// marker_lockstep_ctrl: holds DUT and variant cores in lockstep at phase-marker commits,
// reporting phase, matched-marker count and divergence/timeout/overrun errors.
module marker_lockstep_ctrl #(
    parameter int NLANE   = 2,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NLANE-1:0]      dut_commit_valid,
    input  logic [32*NLANE-1:0]   dut_commit_inst,
    input  logic [NLANE-1:0]      vnt_commit_valid,
    input  logic [32*NLANE-1:0]   vnt_commit_inst,
    output logic                  dut_stall,
    output logic                  vnt_stall,
    output logic [2:0]            phase_id,
    output logic                  phase_active,
    output logic [CNT_W-1:0]      marker_cnt,
    output logic                  sync_pulse,
    output logic                  err,
    output logic [1:0]            err_code
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DWAIT = 3'd2;
    localparam logic [2:0] S_VWAIT = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    // Returns {hit, multi, code}: the lowest-index marker lane and whether a second one exists.
    function automatic logic [5:0] decode(input logic [NLANE-1:0] v, input logic [32*NLANE-1:0] inst);
        logic        hit;
        logic        multi;
        logic [3:0]  code;
        logic [31:0] w;
        hit   = 1'b0;
        multi = 1'b0;
        code  = 4'h0;
        for (int i = 0; i < NLANE; i++) begin
            w = inst[32*i +: 32];
            if (v[i] && w[19:0] == 20'h02013 && w[31:24] == 8'h00 && w[23:20] <= 4'hd) begin
                multi = multi | hit;
                code  = hit ? code : w[23:20];
                hit   = 1'b1;
            end
        end
        return {hit, multi, code};
    endfunction

    logic        d_hit, d_multi, v_hit, v_multi;
    logic [3:0]  d_code, v_code;
    assign {d_hit, d_multi, d_code} = decode(dut_commit_valid, dut_commit_inst);
    assign {v_hit, v_multi, v_code} = decode(vnt_commit_valid, vnt_commit_inst);

    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    wcnt_q, wcnt_d;
    logic [3:0]       lcode_q, lcode_d;
    logic             dut_stall_q, dut_stall_d, vnt_stall_q, vnt_stall_d;
    logic [2:0]       phase_id_q, phase_id_d;
    logic             phase_active_q, phase_active_d;
    logic [CNT_W-1:0] marker_cnt_q, marker_cnt_d;
    logic             sync_pulse_q, sync_pulse_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             match;
    logic [3:0]       mcode;
    logic [1:0]       fail;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        lcode_d    = lcode_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        match      = 1'b0;
        mcode      = lcode_q;
        fail       = 2'd0;
        if (!enable && state_q != S_ERR) begin
            state_d = S_IDLE;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    if (d_multi || v_multi) fail = 2'd3;
                    else if (d_hit && v_hit) begin
                        match = d_code == v_code;
                        mcode = d_code;
                        fail  = match ? 2'd0 : 2'd1;
                    end else if (d_hit || v_hit) begin
                        state_d = d_hit ? S_DWAIT : S_VWAIT;
                        lcode_d = d_hit ? d_code : v_code;
                        wcnt_d  = '0;
                    end
                end
                S_DWAIT, S_VWAIT: begin
                    wcnt_d = wcnt_q + 1'b1;
                    // Marker from the stalled side beats peer match; peer marker beats timeout.
                    if (state_q == S_DWAIT ? (d_hit || v_multi) : (v_hit || d_multi)) fail = 2'd3;
                    else if (state_q == S_DWAIT ? v_hit : d_hit) begin
                        match   = (state_q == S_DWAIT ? v_code : d_code) == lcode_q;
                        fail    = match ? 2'd0 : 2'd1;
                        state_d = S_RUN;
                        wcnt_d  = '0;
                    end else if (wcnt_q == TW'(TIMEOUT - 1)) fail = 2'd2;
                end
                default: ;
            endcase
            if (fail != 2'd0) begin
                state_d    = S_ERR;
                err_d      = 1'b1;
                err_code_d = fail;
            end
        end
        dut_stall_d    = state_d == S_DWAIT;
        vnt_stall_d    = state_d == S_VWAIT;
        sync_pulse_d   = match;
        marker_cnt_d   = marker_cnt_q + CNT_W'(match);
        phase_id_d     = match ? mcode[3:1] : phase_id_q;
        phase_active_d = match ? ~mcode[0] : phase_active_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            wcnt_q         <= '0;
            lcode_q        <= '0;
            dut_stall_q    <= 1'b0;
            vnt_stall_q    <= 1'b0;
            phase_id_q     <= '0;
            phase_active_q <= 1'b0;
            marker_cnt_q   <= '0;
            sync_pulse_q   <= 1'b0;
            err_q          <= 1'b0;
            err_code_q     <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            lcode_q        <= lcode_d;
            dut_stall_q    <= dut_stall_d;
            vnt_stall_q    <= vnt_stall_d;
            phase_id_q     <= phase_id_d;
            phase_active_q <= phase_active_d;
            marker_cnt_q   <= marker_cnt_d;
            sync_pulse_q   <= sync_pulse_d;
            err_q          <= err_d;
            err_code_q     <= err_code_d;
        end
    end

    assign dut_stall    = dut_stall_q;
    assign vnt_stall    = vnt_stall_q;
    assign phase_id     = phase_id_q;
    assign phase_active = phase_active_q;
    assign marker_cnt   = marker_cnt_q;
    assign sync_pulse   = sync_pulse_q;
    assign err          = err_q;
    assign err_code     = err_code_q;
endmodule

// File: tb/tb_marker_lockstep_ctrl.sv
// tb_marker_lockstep_ctrl: directed and randomized checks of marker_lockstep_ctrl against
// a transaction-level model of the pending-marker handshake.
module tb_marker_lockstep_ctrl;
    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  dv = '0, vv = '0;
    logic [63:0] di = '0, vi = '0;
    logic        ds, vs, pact, sp, er;
    logic [2:0]  pid;
    logic [1:0]  cnt, ec;

    int checks = 0;
    int failures = 0;

    int m_on, m_dead, pend, pcode, age;
    logic       e_ds, e_vs, e_pact, e_sp, e_er;
    logic [2:0] e_pid;
    logic [1:0] e_cnt, e_ec;

    marker_lockstep_ctrl #(.NLANE(2), .TIMEOUT(TO), .CNT_W(2)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .dut_commit_valid(dv), .dut_commit_inst(di),
        .vnt_commit_valid(vv), .vnt_commit_inst(vi),
        .dut_stall(ds), .vnt_stall(vs), .phase_id(pid), .phase_active(pact),
        .marker_cnt(cnt), .sync_pulse(sp), .err(er), .err_code(ec)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input int code);
        logic [3:0] c;
        c = code[3:0];
        return {8'h00, c, 20'h02013};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("dut_stall", 32'(ds), 32'(e_ds));
        chk("vnt_stall", 32'(vs), 32'(e_vs));
        chk("phase_id", 32'(pid), 32'(e_pid));
        chk("phase_active", 32'(pact), 32'(e_pact));
        chk("marker_cnt", 32'(cnt), 32'(e_cnt));
        chk("sync_pulse", 32'(sp), 32'(e_sp));
        chk("err", 32'(er), 32'(e_er));
        chk("err_code", 32'(ec), 32'(e_ec));
    endtask

    task automatic model_clear();
        m_on = 0; m_dead = 0; pend = 0; pcode = 0; age = 0;
        e_ds = 0; e_vs = 0; e_pact = 0; e_sp = 0; e_er = 0; e_pid = 0; e_cnt = 0; e_ec = 0;
    endtask

    task automatic dec(input logic [1:0] v, input logic [63:0] inst, output int n, output int c);
        logic [31:0] w;
        n = 0;
        c = 0;
        for (int i = 0; i < 2; i++) begin
            w = inst[32*i +: 32];
            if (v[i] && w[19:0] == 20'h02013 && w[31:24] == 8'h00 && w[23:20] < 4'he) begin
                if (n == 0) c = int'(w[23:20]);
                n++;
            end
        end
    endtask

    // pend: 0 nobody ahead, 1 DUT holds a marker awaiting the variant, 2 the reverse.
    task automatic model(input logic en, input logic [1:0] a_v, input logic [63:0] a_i,
                         input logic [1:0] b_v, input logic [63:0] b_i);
        int dn, dc, vn, vc, own_n, peer_n, peer_c, cause;
        logic hit;
        e_sp = 0;
        hit = 0;
        cause = 0;
        if (m_dead != 0) begin
        end else if (!en) begin
            m_on = 0; pend = 0; age = 0;
        end else if (m_on == 0) begin
            m_on = 1;
        end else begin
            dec(a_v, a_i, dn, dc);
            dec(b_v, b_i, vn, vc);
            if (pend == 0) begin
                if (dn > 1 || vn > 1) cause = 3;
                else if (dn == 1 && vn == 1) begin
                    if (dc == vc) begin hit = 1; pcode = dc; end else cause = 1;
                end else if (dn == 1) begin pend = 1; pcode = dc; age = 0; end
                else if (vn == 1) begin pend = 2; pcode = vc; age = 0; end
            end else begin
                own_n  = pend == 1 ? dn : vn;
                peer_n = pend == 1 ? vn : dn;
                peer_c = pend == 1 ? vc : dc;
                if (own_n > 0 || peer_n > 1) cause = 3;
                else if (peer_n == 1) begin
                    if (peer_c == pcode) begin hit = 1; pend = 0; end else cause = 1;
                end else if (age == TO - 1) cause = 2;
                else age++;
            end
            if (cause != 0) begin m_dead = 1; pend = 0; e_er = 1; e_ec = cause[1:0]; end
            if (hit) begin
                e_sp = 1;
                e_cnt = e_cnt + 2'd1;
                e_pid = 3'(pcode / 2);
                e_pact = (pcode % 2) == 0;
            end
        end
        e_ds = pend == 1;
        e_vs = pend == 2;
    endtask

    task automatic step(input logic en, input logic [1:0] a_v, input logic [63:0] a_i,
                        input logic [1:0] b_v, input logic [63:0] b_i);
        enable = en; dv = a_v; di = a_i; vv = b_v; vi = b_i;
        @(posedge clock);
        model(en, a_v, a_i, b_v, b_i);
        #1;
        chk_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 2'b00, 64'h0, 2'b00, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; enable = 1'b1; dv = '0; vv = '0; di = '0; vi = '0;
        model_clear();
        #1;
        chk_all();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic gen(input logic stalled, input int idx, output int idx_n,
                       output logic [1:0] v, output logic [63:0] inst);
        int lane;
        idx_n = idx;
        v = 2'($urandom_range(0, 3));
        inst = {$urandom | 32'h0100_0000, $urandom | 32'h0100_0000};
        if ($urandom_range(0, 19) == 0) inst[31:0] = {8'h00, 3'b111, 1'($urandom_range(0, 1)), 20'h02013};
        if ((!stalled && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
            lane = $urandom_range(0, 1);
            v[lane] = 1'b1;
            inst[32*lane +: 32] = mk(idx % 14);
            idx_n = idx + 1;
            if ($urandom_range(0, 49) == 0) begin
                v[1-lane] = 1'b1;
                inst[32*(1-lane) +: 32] = mk(idx_n % 14);
            end
        end
    endtask

    initial begin
        int hi, d_idx, v_idx;
        logic en;
        logic [1:0] a_v, b_v;
        logic [63:0] a_i, b_i;

        do_reset();
        step(1'b1, 2'b00, 64'h0, 2'b00, 64'h0);
        chk("run_no_stall", 32'(ds | vs | sp | er), 32'h0);
        idle(8);

        step(1'b1, 2'b01, {32'h0, 32'h00802013}, 2'b00, 64'h0);
        hi = int'(ds);
        for (int i = 0; i < 4; i++) begin idle(1); hi += int'(ds); end
        step(1'b1, 2'b00, 64'h0, 2'b10, {32'h00802013, 32'h0});
        chk("dut_wait_cycles", 32'(hi), 32'd5);
        chk("release_stall", 32'(ds), 32'd0);
        chk("match_pulse", 32'(sp), 32'd1);
        chk("phase_id_4", 32'(pid), 32'd4);
        chk("phase_active_start", 32'(pact), 32'd1);
        chk("cnt_1", 32'(cnt), 32'd1);
        idle(1);
        chk("pulse_one_cycle", 32'(sp), 32'd0);

        step(1'b1, 2'b01, {32'h0, 32'h00902013}, 2'b01, {32'h0, 32'h00902013});
        chk("same_cycle_no_stall", 32'(ds | vs), 32'd0);
        chk("same_cycle_pulse", 32'(sp), 32'd1);
        chk("phase_active_end", 32'(pact), 32'd0);
        chk("cnt_2", 32'(cnt), 32'd2);

        step(1'b0, 2'b00, 64'h0, 2'b00, 64'h0);
        chk("disable_holds_cnt", 32'(cnt), 32'd2);
        idle(2);

        step(1'b1, 2'b01, {32'h0, 32'h00402013}, 2'b00, 64'h0);
        idle(2);
        step(1'b1, 2'b00, 64'h0, 2'b01, {32'h0, 32'h00602013});
        chk("mismatch_code", 32'(ec), 32'd1);
        chk("mismatch_stalls", 32'(ds | vs), 32'd0);
        step(1'b1, 2'b11, {32'h00402013, 32'h00402013}, 2'b00, 64'h0);
        chk("err_sticky", 32'(ec), 32'd1);

        do_reset();
        idle(2);
        step(1'b1, 2'b00, 64'h0, 2'b01, {32'h0, 32'h00202013});
        hi = int'(vs);
        for (int i = 0; i < 12; i++) begin idle(1); hi += int'(vs); end
        chk("timeout_stall_cycles", 32'(hi), 32'd8);
        chk("timeout_code", 32'(ec), 32'd2);
        chk("timeout_stall_off", 32'(vs), 32'd0);

        do_reset();
        idle(2);
        step(1'b1, 2'b11, {32'h00202013, 32'h00002013}, 2'b00, 64'h0);
        chk("overrun_code", 32'(ec), 32'd3);

        do_reset();
        idle(1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'b01, {32'h0, mk(2*k)}, 2'b10, {mk(2*k), 32'h0});
            if (k == 2) chk("cnt_3", 32'(cnt), 32'd3);
        end
        chk("cnt_wrap", 32'(cnt), 32'd0);

        do_reset();
        idle(1);
        step(1'b1, 2'b01, {32'h0, mk(6)}, 2'b00, 64'h0);
        chk("pre_async_stall", 32'(ds), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        chk("async_drop_stall", 32'(ds), 32'd0);
        chk_all();
        @(negedge clock);
        reset = 1'b1;

        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            d_idx = 0;
            v_idx = 0;
            for (int c = 0; c < 250; c++) begin
                en = $urandom_range(0, 39) != 0;
                gen(e_ds, d_idx, d_idx, a_v, a_i);
                gen(e_vs, v_idx, v_idx, b_v, b_i);
                step(en, a_v, a_i, b_v, b_i);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
